l2_writeback_buffer: RTL
========================

// Module: l2_writeback_buffer
// PURPOSE
//  Posted-write buffer between the L2 cache datapath/control and physical memory.
//  Absorbs dirty-line evictions so the following fill read proceeds first.
//  Drains buffered lines to pmem when no read is pending.
//  Serves L2 fill reads that hit a buffered line directly, so stale memory is never returned.
// PARAMETERS
//  DEPTH  2  number of 128-bit line entries; power of 2, >= 1
// PORTS
//  clk          in   1    system clock, rising edge
//  reset        in   1    asynchronous, active-high reset
//  mem_read     in   1    L2 fill request; held high until mem_resp
//  mem_write    in   1    L2 writeback request; held high until mem_resp
//  mem_address  in   16   lc3b_word line address; bits [3:0] ignored
//  mem_wdata    in   128  lc3b_line evicted line
//  mem_resp     out  1    one-cycle completion pulse to L2
//  mem_rdata    out  128  lc3b_line fill data, valid while mem_resp=1
//  pmem_read    out  1    physical memory read strobe
//  pmem_write   out  1    physical memory write strobe
//  pmem_address out  16   lc3b_word, bits [3:0] driven 0
//  pmem_wdata   out  128  lc3b_line drained line
//  pmem_resp    in   1    physical memory completion
//  pmem_rdata   in   128  lc3b_line physical read data
//  full         out  1    all DEPTH entries valid
//  empty        out  1    no entry valid
// BEHAVIOUR
//  - Reset (async): all valids cleared, FSM -> IDLE.
//    - Outputs: mem_resp, pmem_read, pmem_write = 0; pmem_address, pmem_wdata, mem_rdata = 0.
//    - full = 0, empty = 1.
//    - Reset mid-transaction drops pmem strobes immediately; buffered lines are discarded.
//  - Line match: entry valid && entry.addr[15:4] == mem_address[15:4]. At most one entry matches.
//  - FSM states: IDLE, RD_PMEM, WR_PMEM, RESP. Requests are sampled only in IDLE.
//  - IDLE transitions (priority order):
//    1. mem_write && match: overwrite the matching entry (coalesce) -> RESP. Allowed even when full.
//    2. mem_write && !full: push at tail, valid = 1 -> RESP.
//    3. mem_read && match: mem_rdata <= entry data -> RESP. pmem is not touched.
//    4. mem_read && no match -> RD_PMEM.
//    5. !empty && no request -> WR_PMEM; head entry drives pmem_address/pmem_wdata.
//    6. mem_write && full && no match -> WR_PMEM, forced drain. The write is re-evaluated on return to IDLE.
//  - RD_PMEM: pmem_read = 1, pmem_address = mem_address & 16'hFFF0.
//    - On pmem_resp: mem_rdata <= pmem_rdata -> RESP.
//  - WR_PMEM: pmem_write = 1; head address and data held stable.
//    - Not preempted by a read.
//    - On pmem_resp: pop head, clear its valid -> IDLE.
//  - RESP: mem_resp = 1 for exactly one cycle -> IDLE.
//  - Latency, measured from the request cycle in IDLE:
//    - Write accept or read hit: mem_resp in the next cycle.
//    - Read miss: mem_resp one cycle after pmem_resp.
//  - Drain order is strict FIFO. Head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//    - Count is $clog2(DEPTH)+1 bits.
//    - full = (count == DEPTH); empty = (count == 0).
//  - Coalescing writes do not change count or pointers.
//  - mem_read && mem_write together is illegal (bench assertion). RTL gives write priority.
//  - pmem_read && pmem_write are never both 1.
// STRUCTURE
//  - lc3b_types additions:
//    - lc3b_line_addr (logic [11:0]).
//    - lc3b_wbuf_state enum {IDLE, RD_PMEM, WR_PMEM, RESP}.
//  - Sub-module l2_wbuf_array: DEPTH entries {valid, lc3b_line_addr, lc3b_line}.
//    - Owns the head/tail/count logic.
//    - Combinational match port: hit, hit_idx, hit_data.
//  - Top module holds the FSM, mem_rdata register and output muxing.
// TESTING
//  1. Reset asserted mid-WR_PMEM with 2 entries: pmem_write falls the same cycle; empty = 1, full = 0, mem_resp = 0.
//  2. Write line 0x1230 (data A), then read 0x1238: mem_resp next cycle, mem_rdata = A, pmem_read never 1.
//  3. Write 0x1000 (A), then write 0x2000 (B): full = 1.
//     - Then write 0x3000 (C): WR_PMEM drains 0x1000/A first.
//     - Then C is accepted, mem_resp follows; drain order is 0x2000 then 0x3000.
//  4. Buffer holds 0x4000; read 0x5000 issued in IDLE: pmem_read at 0x5000 precedes pmem_write at 0x4000.
//     - mem_rdata = pmem_rdata, one cycle after pmem_resp.
//  5. Full buffer, write 0x2000 with new data D: coalesced, count unchanged, mem_resp next cycle, later drain carries D.
//  6. Random legal traffic against a memory model with a 1–5 cycle pmem_resp delay:
//     - Every read returns the latest written value.
//     - No overflow; strobes are mutually exclusive.

Source files
------------

// File: rtl/l2_writeback_buffer_pkg.sv
// Shared types for the L2 writeback buffer.
//   lc3b_word        16-bit byte address
//   lc3b_line        128-bit cache line
//   lc3b_line_addr   line address (word address bits [15:4])
//   lc3b_wbuf_state  controller state encoding
//   wbuf_entry_t     one buffer slot {valid, line address, line data}
package l2_writeback_buffer_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_addr;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PMEM = 2'd1,
        WR_PMEM = 2'd2,
        RESP    = 2'd3
    } lc3b_wbuf_state;

    typedef struct packed {
        logic          valid;
        lc3b_line_addr addr;
        lc3b_line      data;
    } wbuf_entry_t;

    function automatic lc3b_line_addr line_addr_of(input lc3b_word a);
        return a[15:4];
    endfunction

    function automatic lc3b_word line_base(input lc3b_line_addr la);
        return {la, 4'h0};
    endfunction

endpackage

// File: rtl/l2_writeback_buffer_if.sv
// L2-side memory bus between the L2 cache controller and the writeback buffer.
//   mem_read / mem_write   request strobes, held until mem_resp
//   mem_address            byte address of the line
//   mem_wdata              evicted line
//   mem_resp               one-cycle completion pulse
//   mem_rdata              fill data, valid while mem_resp = 1
// master = L2 cache side, slave = writeback buffer side.
interface l2_writeback_buffer_if;
    import l2_writeback_buffer_pkg::*;

    logic     mem_read;
    logic     mem_write;
    lc3b_word mem_address;
    lc3b_line mem_wdata;
    logic     mem_resp;
    lc3b_line mem_rdata;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );

endinterface

// File: rtl/l2_writeback_buffer_array.sv
// Storage array for the writeback buffer: DEPTH line entries kept as a FIFO.
//   clk, reset          clock, async active-high reset (clears all valids)
//   lookup_addr         line address compared against every valid entry
//   hit/hit_idx/hit_data combinational match result
//   push/push_addr/push_data      append at tail
//   coalesce/coalesce_idx/coalesce_data  overwrite data of an existing entry
//   pop                 retire the head entry
//   head_addr/head_data oldest entry, drives the drain
//   full/empty          occupancy flags
module l2_wbuf_array
    import l2_writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  lc3b_line_addr      lookup_addr,
    output logic               hit,
    output logic [PTR_W-1:0]   hit_idx,
    output lc3b_line           hit_data,
    input  logic               push,
    input  lc3b_line_addr      push_addr,
    input  lc3b_line           push_data,
    input  logic               coalesce,
    input  logic [PTR_W-1:0]   coalesce_idx,
    input  lc3b_line           coalesce_data,
    input  logic               pop,
    output lc3b_line_addr      head_addr,
    output lc3b_line           head_data,
    output logic               full,
    output logic               empty
);

    wbuf_entry_t        entry_q [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    // Explicit wrap keeps DEPTH = 1 correct, where the pointer carries a spare bit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (coalesce) begin
                entry_q[coalesce_idx].data <= coalesce_data;
            end
            if (push) begin
                entry_q[tail_q] <= '{valid: 1'b1, addr: push_addr, data: push_data};
                tail_q          <= ptr_inc(tail_q);
            end
            if (pop) begin
                entry_q[head_q].valid <= 1'b0;
                head_q                <= ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entries are unique per line (writes coalesce), so at most one hits.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_q[i].valid && entry_q[i].addr == lookup_addr) begin
                hit      = 1'b1;
                hit_idx  = PTR_W'(i);
                hit_data = entry_q[i].data;
            end
        end
    end

    assign head_addr = entry_q[head_q].addr;
    assign head_data = entry_q[head_q].data;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/l2_writeback_buffer.sv
// Posted-write buffer between the L2 cache and physical memory. Evictions are
// absorbed so the following fill read goes first; buffered lines drain to pmem
// when no request is pending; fill reads that hit a buffered line are served
// from the buffer so stale memory is never returned.
//   clk, reset                 clock, async active-high reset
//   l2                         L2-side bus (slave modport)
//   pmem_read / pmem_write     physical memory strobes (never both high)
//   pmem_address, pmem_wdata   physical request, address bits [3:0] = 0
//   pmem_resp, pmem_rdata      physical completion and read data
//   full / empty               buffer occupancy
//
// state   | meaning
// IDLE    | sample L2 request, or start a drain when nothing is requested
// RD_PMEM | fill read miss outstanding to pmem
// WR_PMEM | head entry being written to pmem
// RESP    | one-cycle mem_resp to L2
module l2_writeback_buffer
    import l2_writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    l2_writeback_buffer_if.slave    l2,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output lc3b_word                pmem_address,
    output lc3b_line                pmem_wdata,
    input  logic                    pmem_resp,
    input  lc3b_line                pmem_rdata,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    lc3b_wbuf_state     state_q, state_d;
    lc3b_line           rdata_q, rdata_d;
    logic               rdata_load;

    logic               hit;
    logic [PTR_W-1:0]   hit_idx;
    lc3b_line           hit_data;
    logic               push, coalesce, pop;
    lc3b_line_addr      head_addr;
    lc3b_line           head_data;

    l2_wbuf_array #(.DEPTH(DEPTH)) u_array (
        .clk           (clk),
        .reset         (reset),
        .lookup_addr   (line_addr_of(l2.mem_address)),
        .hit           (hit),
        .hit_idx       (hit_idx),
        .hit_data      (hit_data),
        .push          (push),
        .push_addr     (line_addr_of(l2.mem_address)),
        .push_data     (l2.mem_wdata),
        .coalesce      (coalesce),
        .coalesce_idx  (hit_idx),
        .coalesce_data (l2.mem_wdata),
        .pop           (pop),
        .head_addr     (head_addr),
        .head_data     (head_data),
        .full          (full),
        .empty         (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (rdata_load) begin
                rdata_q <= rdata_d;
            end
        end
    end

    // Write wins if L2 ever raises both strobes. A write to a full buffer with
    // no matching line forces one drain; the write is then seen again in IDLE.
    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        coalesce   = 1'b0;
        pop        = 1'b0;
        rdata_load = 1'b0;
        rdata_d    = pmem_rdata;
        case (state_q)
            IDLE: begin
                if (l2.mem_write) begin
                    if (hit) begin
                        coalesce = 1'b1;
                        state_d  = RESP;
                    end else if (!full) begin
                        push    = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WR_PMEM;
                    end
                end else if (l2.mem_read) begin
                    if (hit) begin
                        rdata_load = 1'b1;
                        rdata_d    = hit_data;
                        state_d    = RESP;
                    end else begin
                        state_d = RD_PMEM;
                    end
                end else if (!empty) begin
                    state_d = WR_PMEM;
                end
            end
            RD_PMEM: begin
                if (pmem_resp) begin
                    rdata_load = 1'b1;
                    state_d    = RESP;
                end
            end
            WR_PMEM: begin
                if (pmem_resp) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state_q)
            RD_PMEM: pmem_address = l2.mem_address & 16'hFFF0;
            WR_PMEM: begin
                pmem_address = line_base(head_addr);
                pmem_wdata   = head_data;
            end
            default: ;
        endcase
    end

    assign pmem_read    = (state_q == RD_PMEM);
    assign pmem_write   = (state_q == WR_PMEM);
    assign l2.mem_resp  = (state_q == RESP);
    assign l2.mem_rdata = rdata_q;

endmodule
